// File: rtl/uart_rx_pkt_ctrl.sv
// Receive-side packet controller: sequences the UART receiver, hunts for a sync byte,
// collects a fixed-length payload plus XOR checksum and offers it on a valid/ready port.
module uart_rx_pkt_ctrl #(
    parameter int          PAYLOAD_LEN    = 4,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd100000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfg_enable,
    input  logic [2:0]               cfg_baud,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_data,
    output logic                     rx_en,
    output logic [2:0]               baud_select,
    output logic                     pkt_valid,
    input  logic                     pkt_ready,
    output logic [8*PAYLOAD_LEN-1:0] pkt_data,
    output logic                     chk_err,
    output logic                     tmo_err,
    output logic                     ovf_err,
    output logic [7:0]               err_cnt
);

    localparam logic [2:0] ST_OFF     = 3'd0;
    localparam logic [2:0] ST_HUNT    = 3'd1;
    localparam logic [2:0] ST_PAYLOAD = 3'd2;
    localparam logic [2:0] ST_CHECK   = 3'd3;
    localparam logic [2:0] ST_HOLD    = 3'd4;
    localparam logic [4:0] LAST_IDX   = 5'(PAYLOAD_LEN - 1);

    function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

    logic [2:0]               state_r, state_nx_s;
    logic                     rx_valid_q_r, cap_r, stb_s;
    logic [4:0]               idx_r, idx_nx_s;
    logic [7:0]               chk_r, chk_nx_s;
    logic [19:0]              tmo_cnt_r;
    logic                     tmo_hit_s, store_s, timed_s;
    logic [2:0]               baud_r, baud_nx_s;
    logic                     rx_en_r, pkt_valid_r;
    logic [8*PAYLOAD_LEN-1:0] pkt_data_r;
    logic                     chk_err_r, tmo_err_r, ovf_err_r;
    logic                     chk_err_nx_s, tmo_err_nx_s, ovf_err_nx_s, err_any_s;
    logic [7:0]               err_cnt_r;

    assign stb_s     = rx_valid & ~rx_valid_q_r;
    assign tmo_hit_s = (tmo_cnt_r == (TIMEOUT_CYCLES - 20'd1));
    assign timed_s   = (state_r == ST_PAYLOAD) || (state_r == ST_CHECK);
    assign err_any_s = chk_err_nx_s | tmo_err_nx_s | ovf_err_nx_s;

    // Next-state, datapath updates and error decisions; cfg_enable low overrides all states.
    always_comb begin
        state_nx_s   = state_r;
        idx_nx_s     = idx_r;
        chk_nx_s     = chk_r;
        baud_nx_s    = baud_r;
        store_s      = 1'b0;
        chk_err_nx_s = 1'b0;
        tmo_err_nx_s = 1'b0;
        ovf_err_nx_s = 1'b0;
        if (!cfg_enable) begin
            state_nx_s = ST_OFF;
        end else begin
            case (state_r)
                ST_OFF: begin
                    baud_nx_s  = cfg_baud;
                    state_nx_s = ST_HUNT;
                end
                ST_HUNT: begin
                    if (cap_r && (rx_data == SYNC_BYTE)) begin
                        state_nx_s = ST_PAYLOAD;
                        idx_nx_s   = 5'd0;
                        chk_nx_s   = 8'h00;
                    end else begin
                        state_nx_s = ST_HUNT;
                    end
                end
                ST_PAYLOAD: begin
                    if (cap_r) begin
                        store_s  = 1'b1;
                        chk_nx_s = chk_update(chk_r, rx_data);
                        idx_nx_s = idx_r + 5'd1;
                        if (idx_r == LAST_IDX) begin
                            state_nx_s = ST_CHECK;
                        end else begin
                            state_nx_s = ST_PAYLOAD;
                        end
                    end else if (tmo_hit_s) begin
                        tmo_err_nx_s = 1'b1;
                        state_nx_s   = ST_HUNT;
                    end else begin
                        state_nx_s = ST_PAYLOAD;
                    end
                end
                ST_CHECK: begin
                    if (cap_r) begin
                        if (rx_data == chk_r) begin
                            state_nx_s = ST_HOLD;
                        end else begin
                            chk_err_nx_s = 1'b1;
                            state_nx_s   = ST_HUNT;
                        end
                    end else if (tmo_hit_s) begin
                        tmo_err_nx_s = 1'b1;
                        state_nx_s   = ST_HUNT;
                    end else begin
                        state_nx_s = ST_CHECK;
                    end
                end
                ST_HOLD: begin
                    ovf_err_nx_s = cap_r;
                    if (pkt_valid_r && pkt_ready) begin
                        state_nx_s = ST_HUNT;
                    end else begin
                        state_nx_s = ST_HOLD;
                    end
                end
                default: begin
                    state_nx_s = ST_OFF;
                end
            endcase
        end
    end

    // State, byte-event edge detect, timeout counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_OFF;
            rx_valid_q_r <= 1'b0;
            cap_r        <= 1'b0;
            idx_r        <= 5'd0;
            chk_r        <= 8'h00;
            tmo_cnt_r    <= 20'd0;
            baud_r       <= 3'b000;
            rx_en_r      <= 1'b0;
            pkt_valid_r  <= 1'b0;
            pkt_data_r   <= '0;
            chk_err_r    <= 1'b0;
            tmo_err_r    <= 1'b0;
            ovf_err_r    <= 1'b0;
            err_cnt_r    <= 8'h00;
        end else begin
            state_r      <= state_nx_s;
            rx_valid_q_r <= rx_valid;
            cap_r        <= stb_s;
            idx_r        <= idx_nx_s;
            chk_r        <= chk_nx_s;
            baud_r       <= baud_nx_s;
            rx_en_r      <= (state_nx_s != ST_OFF);
            pkt_valid_r  <= (state_nx_s == ST_HOLD);
            chk_err_r    <= chk_err_nx_s;
            tmo_err_r    <= tmo_err_nx_s;
            ovf_err_r    <= ovf_err_nx_s;
            // Counter restarts on every byte and on any state change, so a new state starts at 0.
            if (cap_r || !timed_s || (state_nx_s != state_r)) begin
                tmo_cnt_r <= 20'd0;
            end else begin
                tmo_cnt_r <= tmo_cnt_r + 20'd1;
            end
            if (err_any_s && (err_cnt_r != 8'hFF)) begin
                err_cnt_r <= err_cnt_r + 8'd1;
            end
            for (int i = 0; i < PAYLOAD_LEN; i++) begin
                if (store_s && (idx_r == 5'(i))) begin
                    pkt_data_r[8*i +: 8] <= rx_data;
                end
            end
        end
    end

    assign rx_en       = rx_en_r;
    assign baud_select = baud_r;
    assign pkt_valid   = pkt_valid_r;
    assign pkt_data    = pkt_data_r;
    assign chk_err     = chk_err_r;
    assign tmo_err     = tmo_err_r;
    assign ovf_err     = ovf_err_r;
    assign err_cnt     = err_cnt_r;

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Directed bench for uart_rx_pkt_ctrl: packet receive, checksum/timeout/overflow errors,
// disable/baud relatch, error-counter saturation and mid-packet reset.
module tb_uart_rx_pkt_ctrl;

    localparam logic [19:0] TMO = 20'd40;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_enable = 1'b0;
    logic [2:0]  cfg_baud = 3'b000;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_en;
    logic [2:0]  baud_select;
    logic        pkt_valid;
    logic        pkt_ready = 1'b0;
    logic [31:0] pkt_data;
    logic        chk_err, tmo_err, ovf_err;
    logic [7:0]  err_cnt;

    int total = 0;
    int bad   = 0;
    int n_chk = 0, n_tmo = 0, n_ovf = 0, n_wide = 0;
    logic chk_p = 1'b0, tmo_p = 1'b0, ovf_p = 1'b0;

    uart_rx_pkt_ctrl #(.PAYLOAD_LEN(4), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .cfg_enable(cfg_enable), .cfg_baud(cfg_baud),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_en(rx_en), .baud_select(baud_select),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_data(pkt_data),
        .chk_err(chk_err), .tmo_err(tmo_err), .ovf_err(ovf_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Error pulse tally, plus detection of any pulse wider than one cycle.
    always @(negedge clk) begin
        n_chk = n_chk + int'(chk_err);
        n_tmo = n_tmo + int'(tmo_err);
        n_ovf = n_ovf + int'(ovf_err);
        if ((chk_err && chk_p) || (tmo_err && tmo_p) || (ovf_err && ovf_p)) n_wide = n_wide + 1;
        chk_p = chk_err;
        tmo_p = tmo_err;
        ovf_p = ovf_err;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns in the cycle after the capture cycle (byte already in internal state).
    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b0;
        tick(); tick();
        rx_valid = 1'b1;
        rx_data  = b;
        tick(); tick();
    endtask

    task automatic send_pkt(input logic [7:0] b0, b1, b2, b3, ck);
        send_byte(8'hA5);
        send_byte(b0); send_byte(b1); send_byte(b2); send_byte(b3);
        send_byte(ck);
    endtask

    task automatic handshake();
        pkt_ready = 1'b1;
        tick();
        pkt_ready = 1'b0;
        total++; if (pkt_valid !== 1'b0) begin $display("FAIL handshake_drop: got %b want 0", pkt_valid); bad++; end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        total++; if (rx_en !== 1'b0) begin $display("FAIL rst_rx_en: got %b want 0", rx_en); bad++; end
        total++; if (baud_select !== 3'b000) begin $display("FAIL rst_baud: got %b want 000", baud_select); bad++; end
        total++; if (pkt_valid !== 1'b0 || pkt_data !== 32'h0) begin $display("FAIL rst_pkt: got %b/%h want 0/0", pkt_valid, pkt_data); bad++; end
        total++; if ({chk_err, tmo_err, ovf_err} !== 3'b000 || err_cnt !== 8'h00) begin $display("FAIL rst_err: got %b/%h want 000/00", {chk_err, tmo_err, ovf_err}, err_cnt); bad++; end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_good_packet();
        cfg_baud   = 3'b011;
        cfg_enable = 1'b1;
        tick();
        total++; if (rx_en !== 1'b1 || baud_select !== 3'b011) begin $display("FAIL enable: got %b/%b want 1/011", rx_en, baud_select); bad++; end
        send_pkt(8'h11, 8'h22, 8'h33, 8'h44, 8'h44);
        total++; if (pkt_valid !== 1'b1 || pkt_data !== 32'h44332211) begin $display("FAIL good_pkt: got %b/%h want 1/44332211", pkt_valid, pkt_data); bad++; end
        tick(); tick(); tick();
        total++; if (pkt_valid !== 1'b1 || pkt_data !== 32'h44332211) begin $display("FAIL good_hold: got %b/%h want 1/44332211", pkt_valid, pkt_data); bad++; end
        handshake();
        total++; if (err_cnt !== 8'd0) begin $display("FAIL good_errcnt: got %0d want 0", err_cnt); bad++; end
    endtask

    task automatic test_chk_error();
        int c0;
        c0 = n_chk;
        send_byte(8'h00);
        send_byte(8'h7E);
        send_pkt(8'h01, 8'h02, 8'h03, 8'h04, 8'h05);
        total++; if (chk_err !== 1'b1 || pkt_valid !== 1'b0) begin $display("FAIL chk_pulse: got %b/%b want 1/0", chk_err, pkt_valid); bad++; end
        tick();
        total++; if (chk_err !== 1'b0 || n_chk - c0 !== 1 || err_cnt !== 8'd1) begin $display("FAIL chk_once: got %b/%0d/%0d want 0/1/1", chk_err, n_chk - c0, err_cnt); bad++; end
        send_pkt(8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22);
        total++; if (pkt_valid !== 1'b1 || pkt_data !== 32'hEFBEADDE) begin $display("FAIL chk_recover: got %b/%h want 1/efbeadde", pkt_valid, pkt_data); bad++; end
        handshake();
    endtask

    task automatic test_timeout();
        int k;
        k = -1;
        send_byte(8'hA5);
        send_byte(8'h11);
        send_byte(8'h22);
        for (int i = 1; i <= int'(TMO) + 10; i++) begin
            tick();
            if (tmo_err === 1'b1) begin k = i; break; end
        end
        total++; if (k !== int'(TMO)) begin $display("FAIL tmo_delay: got %0d want %0d", k, TMO); bad++; end
        tick();
        total++; if (tmo_err !== 1'b0 || err_cnt !== 8'd2 || rx_en !== 1'b1) begin $display("FAIL tmo_after: got %b/%0d/%b want 0/2/1", tmo_err, err_cnt, rx_en); bad++; end
        send_pkt(8'h10, 8'h20, 8'h40, 8'h80, 8'hF0);
        total++; if (pkt_valid !== 1'b1 || pkt_data !== 32'h80402010) begin $display("FAIL tmo_recover: got %b/%h want 1/80402010", pkt_valid, pkt_data); bad++; end
        handshake();
    endtask

    task automatic test_overflow();
        int o0;
        send_pkt(8'h11, 8'h22, 8'h33, 8'h44, 8'h44);
        o0 = n_ovf;
        send_byte(8'h55);
        send_byte(8'hA5);
        send_byte(8'h66);
        tick();
        total++; if (n_ovf - o0 !== 3 || err_cnt !== 8'd5) begin $display("FAIL ovf_count: got %0d/%0d want 3/5", n_ovf - o0, err_cnt); bad++; end
        total++; if (pkt_valid !== 1'b1 || pkt_data !== 32'h44332211) begin $display("FAIL ovf_data: got %b/%h want 1/44332211", pkt_valid, pkt_data); bad++; end
        handshake();
    endtask

    task automatic test_back_to_back();
        pkt_ready = 1'b1;
        send_pkt(8'h01, 8'h02, 8'h04, 8'h08, 8'h0F);
        total++; if (pkt_valid !== 1'b1 || pkt_data !== 32'h08040201) begin $display("FAIL early_ready_valid: got %b/%h want 1/08040201", pkt_valid, pkt_data); bad++; end
        tick();
        total++; if (pkt_valid !== 1'b0) begin $display("FAIL early_ready_accept: got %b want 0", pkt_valid); bad++; end
        pkt_ready = 1'b0;
    endtask

    task automatic test_disable();
        int e0;
        e0 = n_chk + n_tmo + n_ovf;
        cfg_baud = 3'b111;
        tick();
        total++; if (baud_select !== 3'b011) begin $display("FAIL baud_ignored: got %b want 011", baud_select); bad++; end
        send_byte(8'hA5);
        send_byte(8'h11);
        cfg_enable = 1'b0;
        tick();
        total++; if (rx_en !== 1'b0 || pkt_valid !== 1'b0) begin $display("FAIL disable: got %b/%b want 0/0", rx_en, pkt_valid); bad++; end
        for (int i = 0; i < int'(TMO) + 10; i++) tick();
        total++; if (n_chk + n_tmo + n_ovf - e0 !== 0 || err_cnt !== 8'd5) begin $display("FAIL disable_noerr: got %0d/%0d want 0/5", n_chk + n_tmo + n_ovf - e0, err_cnt); bad++; end
        cfg_baud   = 3'b101;
        cfg_enable = 1'b1;
        tick();
        total++; if (rx_en !== 1'b1 || baud_select !== 3'b101) begin $display("FAIL reenable: got %b/%b want 1/101", rx_en, baud_select); bad++; end
        send_pkt(8'hA5, 8'h5A, 8'h00, 8'hFF, 8'h00);
        total++; if (pkt_valid !== 1'b1 || pkt_data !== 32'hFF005AA5) begin $display("FAIL reenable_pkt: got %b/%h want 1/ff005aa5", pkt_valid, pkt_data); bad++; end
        handshake();
    endtask

    task automatic test_saturate_and_reset();
        int c0;
        c0 = n_chk;
        for (int i = 0; i < 260; i++) send_pkt(8'h00, 8'h00, 8'h00, 8'h00, 8'h01);
        tick();
        total++; if (n_chk - c0 !== 260 || err_cnt !== 8'hFF) begin $display("FAIL saturate: got %0d/%h want 260/ff", n_chk - c0, err_cnt); bad++; end
        send_byte(8'hA5);
        send_byte(8'h11);
        reset = 1'b1;
        tick();
        total++; if (rx_en !== 1'b0 || baud_select !== 3'b000 || pkt_valid !== 1'b0 || pkt_data !== 32'h0 || err_cnt !== 8'h00 || {chk_err, tmo_err, ovf_err} !== 3'b000) begin
            $display("FAIL midpkt_reset: got %b/%b/%b/%h/%h/%b want all zero", rx_en, baud_select, pkt_valid, pkt_data, err_cnt, {chk_err, tmo_err, ovf_err}); bad++;
        end
        reset = 1'b0;
        tick();
        total++; if (n_wide !== 0) begin $display("FAIL pulse_width: got %0d wide pulses want 0", n_wide); bad++; end
    endtask

    initial begin
        test_reset();
        test_good_packet();
        test_chk_error();
        test_timeout();
        test_overflow();
        test_back_to_back();
        test_disable();
        test_saturate_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
